// File: rtl/instruction_fetch.sv
// Fetch sequencer: steps the PC addresser, reads opcode plus up to two operand
// bytes from program memory, hands the instruction to the decoder, reloads PC on branch.
module instruction_fetch #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  pc_low,
  input  logic [7:0]  pc_high,
  output logic [4:0]  pc_ctrl,
  output logic [7:0]  pc_data,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  opcode,
  output logic [15:0] operand,
  input  logic        branch_req,
  input  logic [15:0] branch_addr,
  output logic        branch_ack
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned SLOT_W = 2;
  localparam logic [4:0]  PC_INC = 5'b00110;
  localparam logic [4:0]  PC_LDL = 5'b00101;
  localparam logic [4:0]  PC_LDH = 5'b00011;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WAIT, S_STEP, S_OUT, S_LDL, S_LDH
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    wait_q, wait_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [7:0]          opcode_q, opcode_d;
  logic [7:0]          op_lo_q, op_lo_d;
  logic [7:0]          op_hi_q, op_hi_d;
  logic [15:0]         target_q, target_d;
  logic [15:0]         addr_q, addr_d;
  logic [4:0]          pc_ctrl_q, pc_ctrl_d;
  logic [7:0]          pc_data_q, pc_data_d;
  logic                mem_rd_q, mem_rd_d;
  logic                instr_valid_q, instr_valid_d;
  logic                branch_ack_q, branch_ack_d;
  logic [SLOT_W-1:0]   n_ops;

  // Operand bytes still owed by the opcode held in the first slot
  always_comb begin
    n_ops = SLOT_W'(2);
    if (opcode_q[7:6] == 2'b00)      n_ops = SLOT_W'(0);
    else if (opcode_q[7:6] == 2'b01) n_ops = SLOT_W'(1);
  end

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    slot_d        = slot_q;
    opcode_d      = opcode_q;
    op_lo_d       = op_lo_q;
    op_hi_d       = op_hi_q;
    target_d      = target_q;
    addr_d        = addr_q;
    pc_ctrl_d     = 5'b00000;
    pc_data_d     = 8'h00;
    branch_ack_d  = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_ADDR;
      S_ADDR: begin
        addr_d  = {pc_high, pc_low};
        wait_d  = CNT_W'(MEM_LATENCY);
        state_d = S_WAIT;
        if (slot_q == SLOT_W'(0)) begin
          opcode_d = 8'h00;
          op_lo_d  = 8'h00;
          op_hi_d  = 8'h00;
        end
      end
      S_WAIT: begin
        wait_d = wait_q - CNT_W'(1);
        if (wait_q == CNT_W'(1)) begin
          unique case (slot_q)
            SLOT_W'(0): opcode_d = mem_data;
            SLOT_W'(1): op_lo_d  = mem_data;
            default:    op_hi_d  = mem_data;
          endcase
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        slot_d  = slot_q + SLOT_W'(1);
        state_d = (slot_q < n_ops) ? S_ADDR : S_OUT;
      end
      S_OUT: begin
        if (instr_ready) begin
          slot_d = SLOT_W'(0);
          if (branch_req) begin
            target_d = branch_addr;
            state_d  = S_LDL;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      S_LDL:   state_d = S_LDH;
      S_LDH:   state_d = S_ADDR;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so decode them from the state being entered
    mem_rd_d      = (state_d == S_ADDR);
    instr_valid_d = (state_d == S_OUT);
    unique case (state_d)
      S_STEP: pc_ctrl_d = PC_INC;
      S_LDL: begin
        pc_ctrl_d = PC_LDL;
        pc_data_d = target_d[7:0];
      end
      S_LDH: begin
        pc_ctrl_d    = PC_LDH;
        pc_data_d    = target_d[15:8];
        branch_ack_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      wait_q        <= '0;
      slot_q        <= '0;
      opcode_q      <= '0;
      op_lo_q       <= '0;
      op_hi_q       <= '0;
      target_q      <= '0;
      addr_q        <= '0;
      pc_ctrl_q     <= '0;
      pc_data_q     <= '0;
      mem_rd_q      <= 1'b0;
      instr_valid_q <= 1'b0;
      branch_ack_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      slot_q        <= slot_d;
      opcode_q      <= opcode_d;
      op_lo_q       <= op_lo_d;
      op_hi_q       <= op_hi_d;
      target_q      <= target_d;
      addr_q        <= addr_d;
      pc_ctrl_q     <= pc_ctrl_d;
      pc_data_q     <= pc_data_d;
      mem_rd_q      <= mem_rd_d;
      instr_valid_q <= instr_valid_d;
      branch_ack_q  <= branch_ack_d;
    end
  end

  // The PC only settles during ADDR itself, so the address is live then and held after
  assign mem_addr    = (state_q == S_ADDR) ? {pc_high, pc_low} : addr_q;
  assign mem_rd      = mem_rd_q;
  assign pc_ctrl     = pc_ctrl_q;
  assign pc_data     = pc_data_q;
  assign instr_valid = instr_valid_q;
  assign opcode      = opcode_q;
  assign operand     = {op_hi_q, op_lo_q};
  assign branch_ack  = branch_ack_q;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch sequencer for the mpp core, directly upstream of the program counter addresser. It drives the addresser's 5-bit control word and load byte, reads program memory at the current PC, and assembles one opcode plus up to two operand bytes into an instruction. It presents that instruction to the decoder over a valid/ready handshake. On a taken branch it reloads the PC byte by byte.

## Interface
- MEM_LATENCY, 1, cycles from mem_addr/mem_rd to valid mem_data; legal range 1..4.
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- pc_low  in  8  PC low byte from addresser.
- pc_high  in  8  PC high byte from addresser.
- pc_ctrl  out  5  addresser control: bit0 SelDataPC (1 = load pc_data, 0 = increment), bit1 PCHcar, bit2 PCLcar, bits4:3 always 0.
- pc_data  out  8  byte loaded into the PC when bit0 = 1.
- mem_addr  out  16  program memory address, {pc_high, pc_low}.
- mem_rd  out  1  read strobe.
- mem_data  in  8  program memory read data.
- instr_valid  out  1  instruction available.
- instr_ready  in  1  decoder accepts.
- opcode  out  8  fetched opcode.
- operand  out  16  {high byte, low byte}; unfetched bytes read as 0.
- branch_req  in  1  current instruction is a taken branch; sampled only on handshake.
- branch_addr  in  16  branch target; sampled with branch_req.
- branch_ack  out  1  one-cycle pulse when the PC reload completes.

## Operation
- Operand count is taken from opcode[7:6]: 00 → 0, 01 → 1, 10 or 11 → 2. Operand bytes are fetched low first, then high.
- States:
  - IDLE: reset state. Exits to ADDR on the first edge after reset is released.
  - ADDR: mem_addr = {pc_high, pc_low}, mem_rd = 1. Next state is WAIT, with wait counter set to MEM_LATENCY.
  - WAIT: mem_addr is held and mem_rd = 0. The counter decrements each cycle. In the cycle where the counter is 1, mem_data is captured into the current slot (opcode, op_lo or op_hi) at the closing edge, then the state moves to STEP.
  - STEP: pc_ctrl = 5'b00110 for exactly one cycle (PC increment). The slot index advances. If more bytes are due for this opcode, next state is ADDR; otherwise OUT.
  - OUT: instr_valid = 1. opcode and operand are stable until the handshake.
    - On instr_valid & instr_ready with branch_req = 0: next state is ADDR.
    - On instr_valid & instr_ready with branch_req = 1: branch_addr is latched and next state is LDL.
  - LDL: pc_data = target[7:0], pc_ctrl = 5'b00101. Next state is LDH.
  - LDH: pc_data = target[15:8], pc_ctrl = 5'b00011, branch_ack = 1. Next state is ADDR.
- Slot registers are cleared at entry to each new instruction, i.e. in the first ADDR after OUT or LDH.
- pc_ctrl = 0 and pc_data = 0 in every state not listed above.
- branch_req is ignored outside the OUT handshake cycle.

## Timing
- Reset (asynchronous, active-low): state is IDLE. pc_ctrl, pc_data, mem_addr, mem_rd, instr_valid, opcode, operand and branch_ack are all 0, and so are the internal target and wait counter.
- Per-byte cost is 2 + MEM_LATENCY cycles (ADDR, WAIT×L, STEP). With L = 1 this is 3 cycles.
- An instruction with N operands asserts instr_valid (2 + L)·(1 + N) cycles after its first ADDR cycle.
- The PC is sampled in ADDR, one cycle after STEP or LDH. The addresser must settle within one cycle of pc_ctrl.
- Back-to-back throughput: after a handshake, the next ADDR follows on the very next cycle. OUT lasts a minimum of 1 cycle.
- A branch adds exactly 2 cycles (LDL, LDH) before the next ADDR. The next mem_addr equals branch_addr.
- An instruction ready at cycle t whose handshake falls at t + k holds all outputs for k + 1 cycles with no memory activity.
- Reset asserted mid-fetch or mid-branch aborts immediately to IDLE. No partial pc_ctrl pulse persists past the reset edge.
- 16-bit PC wrap (0xFFFF → 0x0000) is owned by the addresser. This block only forwards the PC bytes.

## Test plan
- Reset: hold reset = 0 for 3 cycles with random inputs → all outputs 0. After release, mem_addr = 0x0000 with mem_rd = 1 on the 2nd cycle.
- 0-operand fetch (L = 1): memory[0x0000] = 0x15 → instr_valid at cycle 3 after ADDR, opcode = 0x15, operand = 0x0000, exactly one pc_ctrl = 00110 pulse.
- 2-operand fetch: memory 0x80, 0x34, 0x12 at 0x0000..0x0002 → opcode 0x80, operand 0x1234, instr_valid after 9 cycles, three increment pulses. An opcode of 0x40 instead yields operand = 0x0034.
- Back-pressure: hold instr_ready = 0 for 5 cycles → opcode, operand and instr_valid stay stable, mem_rd = 0 and pc_ctrl = 0 throughout. Releasing instr_ready gives ADDR on the next cycle.
- Branch: handshake with branch_req = 1 and branch_addr = 0x0200 → pc_ctrl = 00101 with pc_data = 0x00, then pc_ctrl = 00011 with pc_data = 0x02 and branch_ack = 1, then mem_addr = 0x0200.
- MEM_LATENCY = 3: 1-operand opcode 0x41 → operand low byte captured on the 3rd WAIT cycle, instr_valid after 10 cycles. Reset asserted during WAIT → immediate IDLE with all outputs 0.
